// File: rtl/neuron_parallel_mac.sv
// rtl/neuron_parallel_mac.sv - LANES-wide parallel MAC neuron with bias, activation and saturating requantise
//
// Purpose:
//   Consumes one INPUT_COUNT-element vector as BEATS = ceil(INPUT_COUNT/LANES)
//   beats of LANES signed fixed-point elements. Each element is multiplied by a
//   weight from a banked weight RAM. The products pass through an adder tree and
//   a saturating 2*DW-bit accumulator. The bias is then added, the activation is
//   applied, and the result is requantised back to DW bits. Weights and bias are
//   loaded through the layer/neuron-addressed cfg bus.
//
// Ports:
//   clk, rst                  rising-edge clock, asynchronous active-high reset
//   cfg_layer, cfg_neuron     config target IDs, matched against LAYER_NUM/NEURON_NUM
//   cfg_wvalid, cfg_wdata     weight write (low DATA_WIDTH bits used)
//   cfg_bvalid, cfg_bdata     bias write (low DATA_WIDTH bits used)
//   cfg_err                   1-cycle pulse when a matched write is dropped outside IDLE
//   in_valid, in_ready        input beat handshake
//   in_data                   LANES packed elements, lane i at [i*DW +: DW]
//   out_valid, out_ready      result handshake, result held until accepted
//   out_data, out_sat         requantised result, saturation seen for this vector
`timescale 1ns/1ps
module neuron_parallel_mac #(
  parameter int LAYER_NUM   = 0,
  parameter int NEURON_NUM  = 0,
  parameter int INPUT_COUNT = 784,
  parameter int LANES       = 4,
  parameter int DATA_WIDTH  = 16,
  parameter int INT_BITS    = 1,
  parameter int ACT_MODE    = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [31:0]                   cfg_layer,
  input  logic [31:0]                   cfg_neuron,
  input  logic                          cfg_wvalid,
  input  logic [31:0]                   cfg_wdata,
  input  logic                          cfg_bvalid,
  input  logic [31:0]                   cfg_bdata,
  output logic                          cfg_err,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [LANES*DATA_WIDTH-1:0]   in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic                          out_sat
);

  localparam int DW         = DATA_WIDTH;
  localparam int F          = DW - INT_BITS;
  localparam int BEATS      = (INPUT_COUNT + LANES - 1) / LANES;
  localparam int LAST_LANES = INPUT_COUNT - (BEATS - 1) * LANES;
  localparam int PW         = 2 * DW;
  localparam int TW         = PW + $clog2(LANES);
  localparam int AW         = PW;
  localparam int BW         = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LW         = (LANES > 1) ? $clog2(LANES) : 1;

  localparam logic [BW-1:0] LAST_ADDR = BW'(BEATS - 1);
  localparam logic [LW-1:0] LAST_BANK = LW'(LAST_LANES - 1);
  localparam logic [LW-1:0] TOP_BANK  = LW'(LANES - 1);

  // Clamp limits expressed at the width of the values being clamped.
  localparam logic signed [TW:0] ACC_MAX = {{(TW + 2 - AW){1'b0}}, {(AW - 1){1'b1}}};
  localparam logic signed [TW:0] ACC_MIN = {{(TW + 2 - AW){1'b1}}, {(AW - 1){1'b0}}};
  localparam logic signed [AW:0] OUT_MAX = {{(AW + 2 - DW){1'b0}}, {(DW - 1){1'b1}}};
  localparam logic signed [AW:0] OUT_MIN = {{(AW + 2 - DW){1'b1}}, {(DW - 1){1'b0}}};
  localparam logic signed [AW:0] HALF    = (AW + 1)'(1) << (F - 1);

  typedef enum logic [2:0] {IDLE, ACCUM, DRAIN, BIAS, ACT, OUT} stateType;

  stateType state;

  // Weight RAM: weight k lives in bank k%LANES at address k/LANES.
  logic signed [DW-1:0] wRam  [LANES][BEATS];
  logic signed [DW-1:0] wRead [LANES];

  logic [LW-1:0]        wBank;
  logic [BW-1:0]        wAddr;
  logic [BW-1:0]        nextAddr;
  logic [1:0]           drainCnt;
  logic signed [DW-1:0] biasReg;
  logic signed [AW-1:0] acc;
  logic                 satFlag;

  logic                 s0Valid;
  logic signed [DW-1:0] s0Data [LANES];
  logic [LANES-1:0]     s0Mask;
  logic                 s1Valid;
  logic signed [PW-1:0] s1Prod [LANES];
  logic                 s2Valid;
  logic signed [TW-1:0] s2Sum;

  logic cfgMatch, cfgHit, wrEn, biasEn, accept, lastBeat;
  logic [BW-1:0] beatIdx;

  logic signed [PW-1:0] prodC [LANES];
  logic signed [TW-1:0] treeC;
  logic signed [TW:0]   accSumC, biasSumC;
  logic                 treeOvf, biasOvf;
  logic [AW-1:0]        treeAcc, biasAcc;
  logic signed [AW:0]   rndC, shC;
  logic signed [DW-1:0] qVal, actVal;
  logic                 qSat;

  logic unusedCfgBits;
  assign unusedCfgBits = ^{cfg_wdata[31:DW], cfg_bdata[31:DW]};

  function automatic logic [AW:0] clampAcc(input logic signed [TW:0] v);
    if (v > ACC_MAX) return {1'b1, ACC_MAX[AW-1:0]};
    if (v < ACC_MIN) return {1'b1, ACC_MIN[AW-1:0]};
    return {1'b0, v[AW-1:0]};
  endfunction

  assign cfgMatch = (cfg_layer == 32'(LAYER_NUM)) && (cfg_neuron == 32'(NEURON_NUM));
  assign cfgHit   = cfgMatch && (cfg_wvalid || cfg_bvalid);
  assign wrEn     = cfgMatch && cfg_wvalid && (state == IDLE);
  assign biasEn   = cfgMatch && cfg_bvalid && (state == IDLE);
  assign accept   = in_valid && in_ready;
  assign beatIdx  = (state == IDLE) ? '0 : nextAddr;
  assign lastBeat = (beatIdx == LAST_ADDR);

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      prodC[i] = s0Mask[i] ? PW'(s0Data[i]) * PW'(wRead[i]) : '0;
    end
    treeC = '0;
    for (int i = 0; i < LANES; i++) begin
      treeC = treeC + TW'(s1Prod[i]);
    end
    accSumC            = (TW + 1)'(acc) + (TW + 1)'(s2Sum);
    {treeOvf, treeAcc} = clampAcc(accSumC);
    biasSumC           = (TW + 1)'(acc) + ((TW + 1)'(biasReg) <<< F);
    {biasOvf, biasAcc} = clampAcc(biasSumC);
  end

  // Round half up, clamp to DW bits, then activation on the clamped value.
  always_comb begin
    rndC = (AW + 1)'(acc) + HALF;
    shC  = rndC >>> F;
    qSat = 1'b0;
    qVal = shC[DW-1:0];
    if (shC > OUT_MAX) begin
      qSat = 1'b1;
      qVal = OUT_MAX[DW-1:0];
    end else if (shC < OUT_MIN) begin
      qSat = 1'b1;
      qVal = OUT_MIN[DW-1:0];
    end
    actVal = qVal;
    if (ACT_MODE == 1 && qVal[DW-1]) actVal = '0;
  end

  // RAM has no reset so weights survive rst; the read is registered with the beat.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (wrEn && wBank == LW'(i)) wRam[i][wAddr] <= cfg_wdata[DW-1:0];
      if (accept) wRead[i] <= wRam[i][beatIdx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
      cfg_err   <= 1'b0;
      wBank     <= '0;
      wAddr     <= '0;
      nextAddr  <= '0;
      drainCnt  <= '0;
      biasReg   <= '0;
      acc       <= '0;
      satFlag   <= 1'b0;
      s0Valid   <= 1'b0;
      s0Mask    <= '0;
      s1Valid   <= 1'b0;
      s2Valid   <= 1'b0;
      s2Sum     <= '0;
      for (int i = 0; i < LANES; i++) begin
        s0Data[i] <= '0;
        s1Prod[i] <= '0;
      end
    end else begin
      cfg_err <= cfgHit && (state != IDLE);

      if (biasEn) biasReg <= cfg_bdata[DW-1:0];
      if (wrEn) begin
        if (wAddr == LAST_ADDR && wBank == LAST_BANK) begin
          wBank <= '0;
          wAddr <= '0;
        end else if (wBank == TOP_BANK) begin
          wBank <= '0;
          wAddr <= wAddr + BW'(1);
        end else begin
          wBank <= wBank + LW'(1);
        end
      end

      // Pad lanes of the final beat are masked so their products are zero.
      s0Valid <= accept;
      if (accept) begin
        for (int i = 0; i < LANES; i++) begin
          s0Data[i] <= in_data[i*DW +: DW];
          s0Mask[i] <= !lastBeat || (i < LAST_LANES);
        end
      end
      s1Valid <= s0Valid;
      if (s0Valid) s1Prod <= prodC;
      s2Valid <= s1Valid;
      if (s1Valid) s2Sum <= treeC;
      if (s2Valid) begin
        acc <= treeAcc;
        if (treeOvf) satFlag <= 1'b1;
      end

      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (accept) begin
            acc      <= '0;
            satFlag  <= 1'b0;
            nextAddr <= BW'(1);
            drainCnt <= '0;
            if (lastBeat) begin
              state    <= DRAIN;
              in_ready <= 1'b0;
            end else begin
              state <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (accept) begin
            if (lastBeat) begin
              state    <= DRAIN;
              in_ready <= 1'b0;
              drainCnt <= '0;
            end else begin
              nextAddr <= nextAddr + BW'(1);
            end
          end
        end
        DRAIN: begin
          // Last S3 update lands on the third edge after acceptance; leaving on
          // the fourth keeps out_valid exactly six edges after the last beat.
          if (drainCnt == 2'd3) state <= BIAS;
          else drainCnt <= drainCnt + 2'd1;
        end
        BIAS: begin
          acc <= biasAcc;
          if (biasOvf) satFlag <= 1'b1;
          state <= ACT;
        end
        ACT: begin
          out_data  <= actVal;
          out_sat   <= satFlag | qSat;
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_parallel_mac.sv
// tb/tb_neuron_parallel_mac.sv - directed self-checking bench for neuron_parallel_mac (ReLU and linear instances)
`timescale 1ns/1ps
module tb_neuron_parallel_mac;
  localparam int DW = 16;
  localparam int LANES = 4;
  localparam int IC = 6;
  localparam int LAYER = 2;
  localparam int NEURON = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] cfg_layer, cfg_neuron, cfg_wdata, cfg_bdata;
  logic cfg_wvalid, cfg_bvalid;
  logic in_valid, out_ready;
  logic [LANES*DW-1:0] in_data;
  logic cfgErrR, inReadyR, outValidR, outSatR;
  logic cfgErrL, inReadyL, outValidL, outSatL;
  logic [DW-1:0] outDataR, outDataL;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  neuron_parallel_mac #(.LAYER_NUM(LAYER), .NEURON_NUM(NEURON), .INPUT_COUNT(IC), .LANES(LANES),
                        .DATA_WIDTH(DW), .INT_BITS(1), .ACT_MODE(1)) dutR (
    .clk(clk), .rst(rst), .cfg_layer(cfg_layer), .cfg_neuron(cfg_neuron),
    .cfg_wvalid(cfg_wvalid), .cfg_wdata(cfg_wdata), .cfg_bvalid(cfg_bvalid), .cfg_bdata(cfg_bdata),
    .cfg_err(cfgErrR), .in_valid(in_valid), .in_ready(inReadyR), .in_data(in_data),
    .out_valid(outValidR), .out_ready(out_ready), .out_data(outDataR), .out_sat(outSatR));

  neuron_parallel_mac #(.LAYER_NUM(LAYER), .NEURON_NUM(NEURON), .INPUT_COUNT(IC), .LANES(LANES),
                        .DATA_WIDTH(DW), .INT_BITS(1), .ACT_MODE(0)) dutL (
    .clk(clk), .rst(rst), .cfg_layer(cfg_layer), .cfg_neuron(cfg_neuron),
    .cfg_wvalid(cfg_wvalid), .cfg_wdata(cfg_wdata), .cfg_bvalid(cfg_bvalid), .cfg_bdata(cfg_bdata),
    .cfg_err(cfgErrL), .in_valid(in_valid), .in_ready(inReadyL), .in_data(in_data),
    .out_valid(outValidL), .out_ready(out_ready), .out_data(outDataL), .out_sat(outSatL));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cfgWrite(input int layer, input int neuron, input logic wv, input logic [15:0] wd,
                          input logic bv, input logic [15:0] bd);
    @(negedge clk);
    cfg_layer  = 32'(layer);
    cfg_neuron = 32'(neuron);
    cfg_wvalid = wv;
    cfg_wdata  = {16'hA5A5, wd};
    cfg_bvalid = bv;
    cfg_bdata  = {16'h5A5A, bd};
    @(posedge clk);
    #1;
    cfg_wvalid = 1'b0;
    cfg_bvalid = 1'b0;
  endtask

  task automatic loadWeights(input logic [15:0] w);
    for (int k = 0; k < IC; k++) cfgWrite(LAYER, NEURON, 1'b1, w, 1'b0, 16'h0);
  endtask

  task automatic sendBeat(input logic [63:0] d);
    @(negedge clk);
    check("in_ready_beat", {inReadyR, inReadyL}, 2'b11);
    in_data  = d;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = '1;
  endtask

  task automatic finishVector(input string tag, input logic [15:0] expR, input logic [15:0] expL,
                              input logic expSat, input int hold);
    int edges = 0;
    while (outValidR !== 1'b1 && edges < 20) begin
      @(posedge clk);
      #1;
      edges++;
    end
    check({tag, "_latency"}, edges, 6);
    check({tag, "_valid_lin"}, outValidL, 1'b1);
    check({tag, "_data_relu"}, outDataR, expR);
    check({tag, "_data_lin"}, outDataL, expL);
    check({tag, "_sat"}, {outSatR, outSatL}, {expSat, expSat});
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check({tag, "_hold"}, {outValidR, inReadyR, outSatR, outDataR}, {1'b1, 1'b0, expSat, expR});
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_handshake"}, {outValidR, outValidL, inReadyR, inReadyL}, 4'b0011);
  endtask

  initial begin
    logic [63:0] quarterB1, quarterB2;
    quarterB1 = {4{16'h2000}};
    quarterB2 = {16'h7FFF, 16'h7FFF, 16'h2000, 16'h2000};
    cfg_layer = '0; cfg_neuron = '0; cfg_wdata = '0; cfg_bdata = '0;
    cfg_wvalid = 1'b0; cfg_bvalid = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    #3;
    check("reset_relu", {outValidR, inReadyR, outSatR, cfgErrR, outDataR}, 0);
    check("reset_lin", {outValidL, inReadyL, outSatL, cfgErrL, outDataL}, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Padding: 6 * 0.25*0.25 = 0.375; pad lanes hold 0x7FFF but must not count
    loadWeights(16'h2000);
    sendBeat(quarterB1);
    sendBeat(quarterB2);
    finishVector("pad", 16'h3000, 16'h3000, 1'b0, 0);

    // Bias -0.5: 0.375 - 0.5 = -0.125 -> ReLU 0, linear 0xF000
    cfgWrite(LAYER, NEURON, 1'b0, 16'h0, 1'b1, 16'hC000);
    check("bias_idle_no_err", cfgErrR, 1'b0);
    sendBeat(quarterB1);
    sendBeat(quarterB2);
    finishVector("bias_act", 16'h0000, 16'hF000, 1'b0, 0);

    // Backpressure: result held for 10 cycles with out_ready low
    sendBeat(quarterB1);
    sendBeat(quarterB2);
    finishVector("backpressure", 16'h0000, 16'hF000, 1'b0, 10);

    // Config rules: mismatched IDs ignored, matched write mid-vector dropped
    cfgWrite(LAYER, NEURON, 1'b0, 16'h0, 1'b1, 16'h0000);
    cfgWrite(LAYER, NEURON + 1, 1'b1, 16'h7FFF, 1'b0, 16'h0);
    check("cfg_neuron_mismatch", {cfgErrR, cfgErrL}, 2'b00);
    cfgWrite(LAYER + 1, NEURON, 1'b1, 16'h7FFF, 1'b1, 16'h7FFF);
    check("cfg_layer_mismatch", {cfgErrR, cfgErrL}, 2'b00);
    sendBeat(quarterB1);
    cfgWrite(LAYER, NEURON, 1'b1, 16'h7FFF, 1'b0, 16'h0);
    check("cfg_drop_err", {cfgErrR, cfgErrL}, 2'b11);
    @(posedge clk);
    #1;
    check("cfg_err_pulse_end", {cfgErrR, cfgErrL}, 2'b00);
    repeat (5) @(negedge clk);
    sendBeat(quarterB2);
    finishVector("cfg_drop", 16'h3000, 16'h3000, 1'b0, 0);

    // Async reset mid-ACCUM clears bias but keeps weights
    cfgWrite(LAYER, NEURON, 1'b0, 16'h0, 1'b1, 16'hC000);
    sendBeat(quarterB1);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_relu", {outValidR, inReadyR, outSatR, cfgErrR, outDataR}, 0);
    check("async_reset_lin", {outValidL, inReadyL, outSatL, cfgErrL, outDataL}, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    sendBeat(quarterB1);
    sendBeat(quarterB2);
    finishVector("reset_rerun", 16'h3000, 16'h3000, 1'b0, 0);

    // Saturation; first weight write also carries bias +0.25
    cfgWrite(LAYER, NEURON, 1'b1, 16'h7FFF, 1'b1, 16'h2000);
    for (int k = 1; k < IC; k++) cfgWrite(LAYER, NEURON, 1'b1, 16'h7FFF, 1'b0, 16'h0);
    sendBeat({4{16'h7FFF}});
    sendBeat({4{16'h7FFF}});
    finishVector("sat_pos", 16'h7FFF, 16'h7FFF, 1'b1, 0);
    sendBeat(64'h0);
    sendBeat({16'h7FFF, 16'h7FFF, 16'h0000, 16'h0000});
    finishVector("zero_bias", 16'h2000, 16'h2000, 1'b0, 0);
    cfgWrite(LAYER, NEURON, 1'b0, 16'h0, 1'b1, 16'h0000);
    sendBeat(64'h0);
    sendBeat({16'h7FFF, 16'h7FFF, 16'h0000, 16'h0000});
    finishVector("zero", 16'h0000, 16'h0000, 1'b0, 0);

    // Negative saturation: 0x7FFF * -1.0 summed six times clamps low
    sendBeat({4{16'h8000}});
    sendBeat({16'h7FFF, 16'h7FFF, 16'h8000, 16'h8000});
    finishVector("sat_neg", 16'h0000, 16'h8000, 1'b1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
